// File: rtl/uart_status_pkg.sv
// Shared constants for the status reporting UART: FSM encoding,
// message text and frame layout.
package uart_status_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;
    localparam logic [1:0] ST_WAIT = 2'd3;

    localparam logic [31:0] MSG_ON  = 32'h4F4E0D0A;
    localparam logic [39:0] MSG_OFF = 40'h4F46460D0A;
    localparam logic [2:0]  LEN_ON  = 3'd4;
    localparam logic [2:0]  LEN_OFF = 3'd5;

    localparam logic [3:0]  STOP_IDX = 4'd9;

    // First character sits in the top byte; shift it up to fetch index idx.
    function automatic logic [7:0] msg_char(input logic st, input logic [2:0] idx);
        logic [39:0] m;
        m = st ? {MSG_ON, 8'h00} : MSG_OFF;
        m = m << {idx, 3'b000};
        return m[39:32];
    endfunction

    function automatic logic [2:0] msg_last(input logic st);
        return st ? LEN_ON - 3'd1 : LEN_OFF - 3'd1;
    endfunction

endpackage

// File: rtl/status_byte_ser.sv
// 8N1 byte serializer with a registered line output. done_o fires early
// so the controller can queue the next byte without an idle gap.
module status_byte_ser
    import uart_status_pkg::*;
#(
    parameter int BIT_CNT = 1085
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic [7:0] data_i,
    output logic       txd_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam int BW = $clog2(BIT_CNT + 1);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BIT_CNT - 1);
    localparam logic [BW-1:0] BAUD_DONE = BW'(BIT_CNT - 3);

    logic [BW-1:0] baud_q, baud_d;
    logic [3:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic          txd_q, txd_d;
    logic          busy_q, busy_d;
    logic          bit_end, stop, load;

    assign bit_end = baud_q == BAUD_LAST;
    assign stop    = bit_q == STOP_IDX;
    assign load    = start_i && (!busy_q || (stop && bit_end));
    // Two cycles of lead time cover the controller's LOAD and SEND states.
    assign done_o  = busy_q && stop && (baud_q == BAUD_DONE);

    always_comb begin
        baud_d = baud_q;
        bit_d  = bit_q;
        sh_d   = sh_q;
        txd_d  = txd_q;
        busy_d = busy_q;
        if (load) begin
            baud_d = '0;
            bit_d  = '0;
            sh_d   = data_i;
            txd_d  = 1'b0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (bit_end) begin
                baud_d = '0;
                if (stop) begin
                    busy_d = 1'b0;
                    bit_d  = '0;
                end else begin
                    bit_d = bit_q + 4'd1;
                    if (bit_q == STOP_IDX - 4'd1) begin
                        txd_d = 1'b1;
                    end else begin
                        txd_d = sh_q[0];
                        sh_d  = {1'b0, sh_q[7:1]};
                    end
                end
            end else begin
                baud_d = baud_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            baud_q <= '0;
            bit_q  <= '0;
            sh_q   <= '0;
            txd_q  <= 1'b1;
            busy_q <= 1'b0;
        end else begin
            baud_q <= baud_d;
            bit_q  <= bit_d;
            sh_q   <= sh_d;
            txd_q  <= txd_d;
            busy_q <= busy_d;
        end
    end

    assign txd_o  = txd_q;
    assign busy_o = busy_q;

endmodule

// File: rtl/uart_status_tx.sv
// Reports en_in over UART as "ON\r\n" / "OFF\r\n" whenever it changes
// or a resend is requested.
module uart_status_tx
    import uart_status_pkg::*;
#(
    parameter int CLK_FREQ = 125000000,
    parameter int UART_BPS = 115200
) (
    input  logic sys_clk,
    input  logic reset,
    input  logic en_in,
    input  logic report_req,
    output logic uart_txd,
    output logic tx_busy
);

    localparam int BIT_CNT = CLK_FREQ / UART_BPS;

    logic [1:0] state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] char_q, char_d;
    logic       msg_q, msg_d;
    logic       last_q, last_d;
    logic       pend_q, pend_d;
    logic       trigger, start_msg;
    logic       ser_start, ser_busy, ser_done;

    // A concurrent request is folded into the message it helps start.
    assign trigger = (en_in != last_q) || pend_q || report_req;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        char_d    = char_q;
        msg_d     = msg_q;
        last_d    = last_q;
        pend_d    = pend_q | report_req;
        ser_start = 1'b0;
        start_msg = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (trigger) begin
                    start_msg = 1'b1;
                    state_d   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                char_d  = msg_char(msg_q, idx_q);
                state_d = ST_SEND;
            end
            ST_SEND: begin
                ser_start = 1'b1;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                if (ser_done) begin
                    if (idx_q != msg_last(msg_q)) begin
                        idx_d   = idx_q + 3'd1;
                        state_d = ST_LOAD;
                    end else if (trigger) begin
                        start_msg = 1'b1;
                        state_d   = ST_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (start_msg) begin
            msg_d  = en_in;
            last_d = en_in;
            pend_d = 1'b0;
            idx_d  = '0;
        end
    end

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            char_q  <= '0;
            msg_q   <= 1'b0;
            last_q  <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            char_q  <= char_d;
            msg_q   <= msg_d;
            last_q  <= last_d;
            pend_q  <= pend_d;
        end
    end

    status_byte_ser #(
        .BIT_CNT(BIT_CNT)
    ) u_ser (
        .clk_i  (sys_clk),
        .rst_ni (reset),
        .start_i(ser_start),
        .data_i (char_q),
        .txd_o  (uart_txd),
        .busy_o (ser_busy),
        .done_o (ser_done)
    );

    assign tx_busy = (state_q != ST_IDLE) || ser_busy;

endmodule

// File: tb/tb_uart_status_tx.sv
// Bench for uart_status_tx: line decoder plus a message-level model
// of what should appear on the wire.
module tb_uart_status_tx;

    logic sys_clk = 1'b0;
    logic reset = 1'b0;
    logic en_in = 1'b0;
    logic report_req = 1'b0;
    logic uart_txd;
    logic tx_busy;

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    uart_status_tx #(
        .CLK_FREQ(1000),
        .UART_BPS(100)
    ) dut (
        .sys_clk   (sys_clk),
        .reset     (reset),
        .en_in     (en_in),
        .report_req(report_req),
        .uart_txd  (uart_txd),
        .tx_busy   (tx_busy)
    );

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0] rx_q[$];
    int         rx_t[$];
    bit         rx_ok[$];
    int         rx_base = 0;
    logic [7:0] exp_q[$];
    bit         m_last = 1'b0;
    int         ev_gap[4];
    bit         ev_tgl[4];

    // Line decoder: samples each bit near its middle.
    initial begin : mon
        logic [7:0] b;
        bit ok;
        int t;
        forever begin
            @(negedge sys_clk);
            if (reset && uart_txd === 1'b0) begin
                t = cyc;
                ok = 1'b1;
                repeat (4) @(negedge sys_clk);
                if (uart_txd !== 1'b0) ok = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    repeat (10) @(negedge sys_clk);
                    b[i] = uart_txd;
                end
                repeat (10) @(negedge sys_clk);
                if (uart_txd !== 1'b1) ok = 1'b0;
                rx_q.push_back(b);
                rx_t.push_back(t);
                rx_ok.push_back(ok);
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_msg(input bit s);
        if (s) begin
            exp_q.push_back(8'h4F);
            exp_q.push_back(8'h4E);
        end else begin
            exp_q.push_back(8'h4F);
            exp_q.push_back(8'h46);
            exp_q.push_back(8'h46);
        end
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (tx_busy && n < 3000) begin
            step();
            n++;
        end
        chk({tag, "_idle_timeout"}, 32'(n < 3000), 1);
        repeat (20) step();
        chk({tag, "_busy_after"}, 32'(tx_busy), 0);
        chk({tag, "_txd_after"}, 32'(uart_txd), 1);
    endtask

    task automatic check_stream(input string tag, input int t_trig);
        int n;
        int d;
        n = rx_q.size() - rx_base;
        chk({tag, "_nbytes"}, n, exp_q.size());
        for (int i = 0; i < exp_q.size() && i < n; i++) begin
            chk($sformatf("%s_byte%0d", tag, i), 32'(rx_q[rx_base + i]), 32'(exp_q[i]));
            chk($sformatf("%s_frame%0d", tag, i), 32'(rx_ok[rx_base + i]), 1);
            if (i > 0)
                chk($sformatf("%s_gap%0d", tag, i),
                    rx_t[rx_base + i] - rx_t[rx_base + i - 1], 100);
        end
        if (n > 0) begin
            d = rx_t[rx_base] - t_trig;
            chk({tag, "_start_delay_1to3"}, 32'(d >= 1 && d <= 3), 1);
        end
        rx_base = rx_q.size();
        exp_q.delete();
    endtask

    task automatic round(input string tag, input bit by_toggle, input int n);
        bit s0;
        int pulses;
        int t;
        pulses = 0;
        if (by_toggle) en_in = ~en_in;
        else report_req = 1'b1;
        s0 = en_in;
        t = cyc;
        step();
        report_req = 1'b0;
        for (int i = 0; i < n; i++) begin
            repeat (ev_gap[i]) step();
            if (ev_tgl[i]) begin
                en_in = ~en_in;
            end else begin
                report_req = 1'b1;
                pulses++;
                step();
                report_req = 1'b0;
            end
        end
        push_msg(s0);
        if (en_in != s0 || pulses > 0) begin
            push_msg(en_in);
            m_last = en_in;
        end else begin
            m_last = s0;
        end
        wait_idle(tag);
        check_stream(tag, t);
    endtask

    initial begin
        int t;
        int nb;
        int lim;
        int cnt;

        en_in = 1'b1;
        repeat (3) step();
        chk("rst_txd", 32'(uart_txd), 1);
        chk("rst_busy", 32'(tx_busy), 0);

        reset = 1'b1;
        t = cyc;
        step();
        wait_idle("boot_on");
        push_msg(1'b1);
        check_stream("boot_on", t);
        m_last = 1'b1;

        en_in = 1'b0;
        t = cyc;
        nb = 0;
        lim = 0;
        while ((tx_busy || nb == 0) && lim < 1200) begin
            step();
            if (tx_busy) nb++;
            lim++;
        end
        chk("off_busy_cycles_500to503", 32'(nb >= 500 && nb <= 503), 1);
        wait_idle("off");
        push_msg(1'b0);
        check_stream("off", t);
        m_last = 1'b0;

        en_in = 1'b1;
        report_req = 1'b1;
        t = cyc;
        step();
        report_req = 1'b0;
        wait_idle("same_cycle");
        push_msg(1'b1);
        check_stream("same_cycle", t);
        m_last = 1'b1;

        ev_gap = '{125, 20, 0, 0};
        ev_tgl = '{1'b1, 1'b1, 1'b0, 1'b0};
        round("toggle_back", 1'b1, 2);

        ev_gap = '{30, 40, 50, 0};
        ev_tgl = '{1'b0, 1'b0, 1'b0, 1'b0};
        round("req3", 1'b1, 3);

        for (int r = 0; r < 10; r++) begin
            int n;
            n = $urandom_range(0, 4);
            for (int i = 0; i < n; i++) begin
                ev_gap[i] = $urandom_range(5, 60);
                ev_tgl[i] = 1'($urandom % 2);
            end
            round($sformatf("rnd%0d", r), 1'($urandom % 2), n);
        end

        en_in = ~en_in;
        step();
        lim = 0;
        while (uart_txd !== 1'b0 && lim < 20) begin
            step();
            lim++;
        end
        chk("midbit_start_seen", 32'(lim < 20), 1);
        repeat (55) step();
        chk("midbit_pre_txd", 32'(uart_txd), 0);
        reset = 1'b0;
        #1;
        chk("midbit_rst_txd", 32'(uart_txd), 1);
        chk("midbit_rst_busy", 32'(tx_busy), 0);
        en_in = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        cnt = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (tx_busy || !uart_txd) cnt++;
        end
        chk("post_rst_quiet", cnt, 0);
        rx_base = rx_q.size();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_status_tx.md
UART_STATUS_TX -- requirements
Module: uart_status_tx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 125000000, system clock frequency in Hz.
REQ-002 SHALL have parameter UART_BPS, default 115200, serial baud rate.
REQ-003 SHALL have port sys_clk  input  1  system clock; one clock only.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port en_in  input  1  status level to report; synchronous to sys_clk.
REQ-006 SHALL have port report_req  input  1  single-cycle pulse requesting a resend of the current status.
REQ-007 SHALL have port uart_txd  output  1  UART serial output; idle high.
REQ-008 SHALL have port tx_busy  output  1  high while any message byte is in flight.

Function
REQ-009 SHALL derive BIT_CNT = CLK_FREQ/UART_BPS (integer division; 1085 at defaults) and hold each serial bit for exactly BIT_CNT cycles.
REQ-010 SHALL send each byte as 1 start bit (0), 8 data bits LSB first, then 1 stop bit (1): 10*BIT_CNT cycles per byte, with no idle gap between bytes of one message.
REQ-011 SHALL report status 1 as ASCII "ON\r\n" (0x4F 0x4E 0x0D 0x0A) and status 0 as "OFF\r\n" (0x4F 0x46 0x46 0x0D 0x0A).
REQ-012 SHALL keep a register last_sent, reset value 0, holding the status of the most recent message started.
REQ-013 SHALL start a message when idle and either en_in != last_sent or a report_req is pending; the first start bit appears on uart_txd at most 3 cycles after the triggering edge.
REQ-014 SHALL latch the status to send at message start; en_in changes during a message SHALL NOT alter the bytes of that message.
REQ-015 SHALL, when a message completes and en_in != last_sent, start the next message without returning through a visible idle bit time.
REQ-016 SHALL latch report_req into a one-deep pending flag; multiple requests during one message SHALL produce exactly one resend; the flag SHALL clear when the resulting message starts.
REQ-017 SHALL give priority to a status change over a pending report_req when both are present at a start decision; one message SHALL serve both.
REQ-018 SHALL implement a control FSM with states IDLE, LOAD (fetch character), SEND (pulse serializer start), WAIT (until byte done); transitions: IDLE->LOAD on trigger; LOAD->SEND; SEND->WAIT; WAIT->LOAD on byte done with characters remaining; WAIT->IDLE on last byte done with no trigger; WAIT->LOAD (index 0) on last byte done with a trigger.
REQ-019 SHALL assert tx_busy from the cycle after the trigger until the stop bit of the final byte ends.
REQ-020 SHALL register uart_txd (no combinational glitches).

Reset
REQ-021 SHALL, on reset low, immediately force uart_txd=1, tx_busy=0, FSM=IDLE, last_sent=0, pending flag=0, and bit/baud/character counters=0, including mid-byte.
REQ-022 SHALL, after reset release with en_in=1, send "ON\r\n" once; with en_in=0, SHALL send nothing.

Structure
REQ-023 SHALL place the FSM state encoding, the ASCII message constants, and message lengths (4, 5) in a shared package uart_status_pkg.
REQ-024 SHALL use one sub-module, status_byte_ser (byte start/busy/done handshake, baud counter, bit counter, shift register), with the control FSM in the top level.

Verification (CLK_FREQ=1000, UART_BPS=100, so BIT_CNT=10)
REQ-025 SHALL cover: reset release with en_in=1 -> "ON\r\n" on uart_txd, 40 bits of 10 cycles each, then tx_busy=0 and line high.
REQ-026 SHALL cover: en_in 1->0 while idle -> "OFF\r\n", 500 cycles busy, first start bit within 3 cycles.
REQ-027 SHALL cover: en_in toggles 0->1->0 during byte 2 of "OFF\r\n" -> that message completes unchanged and no further message follows (final en_in == last_sent).
REQ-028 SHALL cover: three report_req pulses during "ON\r\n" -> exactly one extra "ON\r\n", back-to-back with the first.
REQ-029 SHALL cover: reset asserted mid-data-bit -> uart_txd=1 in the same cycle; after release with en_in=0, line stays idle.
REQ-030 SHALL cover: en_in change and report_req in the same cycle while idle -> exactly one message with the new status.
